// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_control_unit_pkg
// Brief  : Shared encodings for the hazard control unit and its counters.
// Rev    : 1.0
// ============================================================================
package hazard_control_unit_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    localparam logic [1:0] ALU1_PC   = 2'd0;
    localparam logic [1:0] ALU1_A    = 2'd1;
    localparam logic [1:0] ALU1_FWD  = 2'd2;
    localparam logic [1:0] ALU1_ZERO = 2'd3;

    localparam logic [1:0] ALU2_B      = 2'd0;
    localparam logic [1:0] ALU2_CONST2 = 2'd1;
    localparam logic [1:0] ALU2_IMM    = 2'd2;
    localparam logic [1:0] ALU2_FWD    = 2'd3;

    localparam logic [1:0] SRC1_PC   = 2'd0;
    localparam logic [1:0] SRC1_REG  = 2'd1;
    localparam logic [1:0] SRC1_ALT  = 2'd2;
    localparam logic [1:0] SRC1_ZERO = 2'd3;

    localparam logic [1:0] SRC2_REG    = 2'd0;
    localparam logic [1:0] SRC2_CONST2 = 2'd1;
    localparam logic [1:0] SRC2_IMM    = 2'd2;
    localparam logic [1:0] SRC2_ALT    = 2'd3;

    localparam logic [3:0] REG_ZERO = 4'd0;

    function automatic logic src1_is_reg(input logic [1:0] src);
        return (src == SRC1_REG) || (src == SRC1_ALT);
    endfunction

    function automatic logic src2_is_reg(input logic [1:0] src);
        return (src == SRC2_REG) || (src == SRC2_ALT);
    endfunction

    // The unused source codes alias onto the register path.
    function automatic logic [1:0] map_src1(input logic [1:0] src);
        return (src == SRC1_ALT) ? ALU1_A : src;
    endfunction

    function automatic logic [1:0] map_src2(input logic [1:0] src);
        return (src == SRC2_ALT) ? ALU2_B : src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter16.sv
`default_nettype none
// ============================================================================
// Module : sat_counter16
// Brief  : 16-bit event counter that saturates at all-ones.
// Rev    : 1.0
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_control_unit
// Brief  : Forwarding select, load-use stall and taken-branch flush control.
// Rev    : 1.0
// ============================================================================
module hazard_control_unit
    import hazard_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [3:0]  dec_rs1,
    input  logic [3:0]  dec_rs2,
    input  logic [1:0]  dec_src1,
    input  logic [1:0]  dec_src2,
    input  logic [3:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_is_load,
    input  logic        ex_branch,
    input  logic        ex_taken,
    output logic [1:0]  aluin1,
    output logic [1:0]  aluin2,
    output logic        stall,
    output logic        flush_if,
    output logic        flush_id,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    logic       w_match1;
    logic       w_match2;
    logic       w_load_use;
    logic       w_br;
    logic       w_fwd1;
    logic       w_fwd2;
    logic       w_stall;
    logic       w_flush_if;
    logic       w_flush_id;
    logic [1:0] w_state_next;
    logic [1:0] r_state;
    logic [1:0] r_aluin1;
    logic [1:0] r_aluin2;

    assign w_match1 = ex_regwrite && (ex_rd != REG_ZERO) && (ex_rd == dec_rs1)
                      && src1_is_reg(dec_src1);
    assign w_match2 = ex_regwrite && (ex_rd != REG_ZERO) && (ex_rd == dec_rs2)
                      && src2_is_reg(dec_src2);

    assign w_load_use = dec_valid && ex_is_load && (w_match1 || w_match2);
    assign w_br       = ex_branch && ex_taken;

    // A load result is not available in execute, so it is never forwarded.
    assign w_fwd1 = dec_valid && w_match1 && !ex_is_load;
    assign w_fwd2 = dec_valid && w_match2 && !ex_is_load;

    always_comb begin
        w_stall      = 1'b0;
        w_flush_if   = 1'b0;
        w_flush_id   = 1'b0;
        w_state_next = ST_RUN;
        if (w_br) begin
            w_flush_if   = 1'b1;
            w_flush_id   = 1'b1;
            w_state_next = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        w_stall      = 1'b1;
                        w_flush_id   = 1'b1;
                        w_state_next = ST_LSTALL;
                    end
                end
                ST_LSTALL: begin
                    w_stall    = 1'b1;
                    w_flush_id = 1'b1;
                end
                ST_FLUSH: begin
                    w_flush_if = 1'b1;
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
        if (rst) begin
            w_stall    = 1'b0;
            w_flush_if = 1'b0;
            w_flush_id = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_aluin1 <= ALU1_A;
            r_aluin2 <= ALU2_B;
        end else begin
            r_state <= w_state_next;
            if (w_flush_id) begin
                r_aluin1 <= ALU1_A;
                r_aluin2 <= ALU2_B;
            end else begin
                r_aluin1 <= w_fwd1 ? ALU1_FWD : map_src1(dec_src1);
                r_aluin2 <= w_fwd2 ? ALU2_FWD : map_src2(dec_src2);
            end
        end
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (stall_count)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_br),
        .count (flush_count)
    );

    assign stall    = w_stall;
    assign flush_if = w_flush_if;
    assign flush_id = w_flush_id;
    assign state    = r_state;
    assign aluin1   = r_aluin1;
    assign aluin2   = r_aluin2;

endmodule
`default_nettype wire

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-003 SHALL have inputs dec_valid (1), dec_rs1 (4), dec_rs2 (4), dec_src1 (2: 0 pc, 1 reg, 3 zero, 2 treated as reg), dec_src2 (2: 0 reg, 1 const 2, 2 imm, 3 treated as reg) for the instruction in decode.
REQ-004 SHALL have inputs ex_rd (4), ex_regwrite (1), ex_is_load (1), ex_branch (1), ex_taken (1) for the instruction in execute.
REQ-005 SHALL have outputs aluin1 (2) and aluin2 (2), registered operand-mux selects for the execute stage. aluin1 encoding: 0 pc, 1 a, 2 forwarded, 3 zero. aluin2 encoding: 0 b, 1 const 2, 2 imm, 3 forwarded.
REQ-006 SHALL have combinational outputs stall (1), which holds the PC and IF/ID, flush_if (1), which kills IF/ID, and flush_id (1), which inserts a bubble into ID/EX.
REQ-007 SHALL have outputs state (2), stall_count (16) and flush_count (16).

Function
REQ-008 States SHALL be RUN=0, LSTALL=1 and FLUSH=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-009 match1 SHALL be ex_regwrite & (ex_rd!=0) & (ex_rd==dec_rs1) & dec_src1 selects a register. match2 SHALL be defined the same way for rs2/src2. Register 0 never matches.
REQ-010 load_use SHALL be dec_valid & ex_is_load & (match1|match2).
REQ-011 br SHALL be ex_branch & ex_taken. br has priority over load_use in every state.
REQ-012 In RUN with br: flush_if=1, flush_id=1, stall=0; next state FLUSH.
REQ-013 In RUN with load_use and no br: stall=1, flush_id=1; next state LSTALL.
REQ-014 In RUN with neither br nor load_use: all three control outputs are 0; next state RUN.
REQ-015 LSTALL SHALL last exactly 1 cycle with stall=1 and flush_id=1, then go to RUN. The total load-use penalty is 2 cycles, and the register file is write-through.
REQ-016 FLUSH SHALL last exactly 1 cycle with flush_if=1, stall=0, flush_id=0, then go to RUN. This covers the one-cycle registered pcwrite redirect.
REQ-017 br in LSTALL or FLUSH SHALL be handled as in RUN: flush_if=1, flush_id=1, next state FLUSH.
REQ-018 On each edge with flush_id=1, aluin1 SHALL load 1 and aluin2 SHALL load 0 (bubble defaults).
REQ-019 On each edge with flush_id=0, aluin1 SHALL load 2 if match1 & !ex_is_load, else dec_src1 (with 2 mapped to 1).
REQ-020 On each edge with flush_id=0, aluin2 SHALL load 3 if match2 & !ex_is_load, else dec_src2 (with 3 mapped to 0).
REQ-021 When dec_valid=0, the selects SHALL take their non-forwarded values, and load_use is 0.
REQ-022 stall_count SHALL increment on each cycle with stall=1. flush_count SHALL increment on each cycle with br=1.
REQ-023 Both counters SHALL saturate at 0xFFFF; they do not wrap.

Reset
REQ-024 While rst=1, the next edge SHALL set state=RUN, aluin1=1, aluin2=0, stall_count=0 and flush_count=0.
REQ-025 While rst=1, stall, flush_if and flush_id SHALL be forced to 0 combinationally, regardless of the other inputs.
REQ-026 Reset asserted mid-LSTALL or mid-FLUSH SHALL abandon the sequence; no residual stall or flush follows deassertion.

Structure
REQ-027 A shared package SHALL hold the state encodings, the aluin1/aluin2 select constants, the dec_src encodings and REG_ZERO=4'd0.
REQ-028 A sub-module sat_counter16 (clk, rst, inc, count) SHALL be instantiated twice, for stall_count and flush_count.
REQ-029 Hazard compare logic SHALL stay in the top module; no further hierarchy.

Verification
REQ-030 Forward test: ex_rd=3, ex_regwrite=1, ex_is_load=0; dec_rs1=3, dec_src1=1, dec_rs2=5, dec_src2=0. Required: after the next edge aluin1=2, aluin2=0, and stall=0.
REQ-031 Zero-register test: ex_rd=0 with ex_regwrite=1 matching dec_rs1=0. Required: no forward (aluin1=1) and no stall.
REQ-032 Load-use test: ex_is_load=1, ex_rd=4, dec_rs2=4, dec_src2=0. Required: stall=1 for exactly 2 cycles, state sequence RUN->LSTALL->RUN, stall_count=2, and aluin2=0 during the bubble.
REQ-033 Branch test: ex_branch=1 with ex_taken=1. Required: flush_if=1 for 2 consecutive cycles, flush_id=1 in the first cycle only, and flush_count=1.
REQ-034 Simultaneous test: br and load_use in the same cycle. Required: branch path only (state FLUSH, stall=0).
REQ-035 Reset test: rst pulsed during LSTALL. Required: next cycle state=RUN, stall=0 and counters=0.
REQ-036 Saturation test: force stall_count to 0xFFFE, then 3 stall cycles. Required: stall_count holds at 0xFFFF.
